// File: rtl/fp_wb_arbiter_pkg.sv
// Shared FP writeback package: source encodings, widths, flag struct and output-stage states.
package fp_wb_arbiter_pkg;

    localparam int DATA_W        = 32;
    localparam int RD_W          = 5;
    localparam int FLAG_W        = 5;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic [1:0] FP_SRC_FADD = 2'd0;
    localparam logic [1:0] FP_SRC_FMUL = 2'd1;
    localparam logic [1:0] FP_SRC_FDIV = 2'd2;
    localparam logic [1:0] FP_SRC_FCVT = 2'd3;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    function automatic logic [3:0] oneHot4(input logic [1:0] idx);
        oneHot4 = 4'b0001 << idx;
    endfunction

    function automatic logic [2:0] popCount4(input logic [3:0] vec);
        popCount4 = 3'(vec[0]) + 3'(vec[1]) + 3'(vec[2]) + 3'(vec[3]);
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Source-side and register-file-side signals of the FP writeback arbiter.
interface fp_wb_arbiter_if
    import fp_wb_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [3:0]        src_valid;
    logic [3:0]        src_ready;
    logic [DATA_W-1:0] src_data0, src_data1, src_data2, src_data3;
    logic [RD_W-1:0]   src_rd0, src_rd1, src_rd2, src_rd3;
    logic [FLAG_W-1:0] src_flags0, src_flags1, src_flags2, src_flags3;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic [FLAG_W-1:0] wb_flags;
    logic [1:0]        wb_src;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output src_valid, src_data0, src_data1, src_data2, src_data3,
               src_rd0, src_rd1, src_rd2, src_rd3,
               src_flags0, src_flags1, src_flags2, src_flags3, wb_ready,
        input  src_ready, wb_valid, wb_data, wb_rd, wb_flags, wb_src, conflict_cnt
    );

    modport slave (
        input  src_valid, src_data0, src_data1, src_data2, src_data3,
               src_rd0, src_rd1, src_rd2, src_rd3,
               src_flags0, src_flags1, src_flags2, src_flags3, wb_ready,
        output src_ready, wb_valid, wb_data, wb_rd, wb_flags, wb_src, conflict_cnt
    );
endinterface

// File: rtl/fp_wb_arbiter_mux.sv
// Generic 4:1 mux used for the result, destination and flag selection.
module Mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_in0,
    input  logic [W-1:0] i_in1,
    input  logic [W-1:0] i_in2,
    input  logic [W-1:0] i_in3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_out
);
    always_comb begin
        o_out = i_in0;
        case (i_sel)
            2'd1:    o_out = i_in1;
            2'd2:    o_out = i_in2;
            2'd3:    o_out = i_in3;
            default: o_out = i_in0;
        endcase
    end
endmodule

// File: rtl/fp_wb_arbiter_rr.sv
// Combinational 4-way round-robin picker: first requester at or after ptr, wrapping 3->0.
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);
    logic [1:0] w_idx;

    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = ptr + 2'(k);
            if (!any && req[w_idx]) begin
                gnt_idx = w_idx;
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_wb_arbiter.sv
// FP32 writeback arbiter: round-robin grant over four FP units into a one-entry
// registered output stage with valid/ready toward the register-file write port.
module fp_wb_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    fp_wb_arbiter_if.slave     bus
);
    wb_state_e         r_state;
    wb_state_e         w_stateNext;
    logic [1:0]        r_rrPtr;
    logic [DATA_W-1:0] r_wbData;
    logic [RD_W-1:0]   r_wbRd;
    fp_flags_t         r_wbFlags;
    logic [1:0]        r_wbSrc;
    logic [CNT_W-1:0]  r_conflictCnt;

    logic [1:0]        w_gntIdx;
    logic              w_any;
    logic              w_loadEn;
    logic              w_accept;
    logic              w_conflict;
    logic [DATA_W-1:0] w_muxData;
    logic [RD_W-1:0]   w_muxRd;
    logic [FLAG_W-1:0] w_muxFlags;

    rr_arbiter_4 u_rr (
        .req     (bus.src_valid),
        .ptr     (r_rrPtr),
        .gnt_idx (w_gntIdx),
        .any     (w_any)
    );

    Mux4 #(.W(DATA_W)) u_muxData (
        .i_in0 (bus.src_data0), .i_in1 (bus.src_data1),
        .i_in2 (bus.src_data2), .i_in3 (bus.src_data3),
        .i_sel (w_gntIdx),      .o_out (w_muxData)
    );

    Mux4 #(.W(RD_W)) u_muxRd (
        .i_in0 (bus.src_rd0), .i_in1 (bus.src_rd1),
        .i_in2 (bus.src_rd2), .i_in3 (bus.src_rd3),
        .i_sel (w_gntIdx),    .o_out (w_muxRd)
    );

    Mux4 #(.W(FLAG_W)) u_muxFlags (
        .i_in0 (bus.src_flags0), .i_in1 (bus.src_flags1),
        .i_in2 (bus.src_flags2), .i_in3 (bus.src_flags3),
        .i_sel (w_gntIdx),       .o_out (w_muxFlags)
    );

    assign w_conflict = (popCount4(bus.src_valid) >= 3'd2);

    // A full stage that is draining this cycle may be refilled on the same edge.
    always_comb begin
        w_loadEn      = (r_state == WB_EMPTY) || bus.wb_ready;
        w_accept      = w_loadEn && w_any && !flush && !rst;
        bus.src_ready = w_accept ? oneHot4(w_gntIdx) : 4'b0000;
        w_stateNext   = r_state;
        case (r_state)
            WB_EMPTY: begin
                if (w_accept) w_stateNext = WB_FULL;
            end
            WB_FULL: begin
                if (flush)             w_stateNext = WB_EMPTY;
                else if (w_accept)     w_stateNext = WB_FULL;
                else if (bus.wb_ready) w_stateNext = WB_EMPTY;
            end
            default: w_stateNext = WB_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= WB_EMPTY;
            r_rrPtr       <= 2'd0;
            r_wbData      <= '0;
            r_wbRd        <= '0;
            r_wbFlags     <= '0;
            r_wbSrc       <= 2'd0;
            r_conflictCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_wbData  <= w_muxData;
                r_wbRd    <= w_muxRd;
                r_wbFlags <= fp_flags_t'(w_muxFlags);
                r_wbSrc   <= w_gntIdx;
                r_rrPtr   <= w_gntIdx + 2'd1;
            end
            if (w_conflict && (r_conflictCnt != {CNT_W{1'b1}})) begin
                r_conflictCnt <= r_conflictCnt + CNT_W'(1);
            end
        end
    end

    assign bus.wb_valid     = (r_state == WB_FULL);
    assign bus.wb_data      = r_wbData;
    assign bus.wb_rd        = r_wbRd;
    assign bus.wb_flags     = r_wbFlags;
    assign bus.wb_src       = r_wbSrc;
    assign bus.conflict_cnt = r_conflictCnt;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: grant order, stall, drain+fill, flush, saturation, reset.
module tb_fp_wb_arbiter;
    import fp_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   checkCount;
    int   failCount;

    fp_wb_arbiter_if bus ();

    fp_wb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready, input logic fl);
        bus.src_valid = valid;
        bus.wb_ready  = ready;
        flush         = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dataOf(input int i);
        dataOf = 32'hA000_0000 + 32'(i);
    endfunction

    // Expected grant order with all four requesting and pointer starting at 0.
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.src_valid = 4'b0000;
        bus.wb_ready = 1'b0;
        bus.src_data0 = dataOf(0); bus.src_data1 = dataOf(1);
        bus.src_data2 = 32'h3F80_0000; bus.src_data3 = dataOf(3);
        bus.src_rd0 = 5'd10; bus.src_rd1 = 5'd11; bus.src_rd2 = 5'd5; bus.src_rd3 = 5'd13;
        bus.src_flags0 = 5'b00001; bus.src_flags1 = 5'b00010;
        bus.src_flags2 = 5'b00100; bus.src_flags3 = 5'b01000;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        checkOutput("rst_wb_data", bus.wb_data, 32'd0);
        checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        checkOutput("rst_wb_flags", 32'(bus.wb_flags), 32'd0);
        checkOutput("rst_wb_src", 32'(bus.wb_src), 32'd0);
        checkOutput("rst_src_ready", 32'(bus.src_ready), 32'd0);
        checkOutput("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
        checkOutput("rst_rr_ptr", 32'(dut.r_rrPtr), 32'd0);

        // Single source 2 request, one-cycle latency to wb_valid.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t1_src_ready", 32'(bus.src_ready), 32'b0100);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
        checkOutput("t1_wb_data", bus.wb_data, 32'h3F80_0000);
        checkOutput("t1_wb_rd", 32'(bus.wb_rd), 32'd5);
        checkOutput("t1_wb_flags", 32'(bus.wb_flags), 32'b00100);
        checkOutput("t1_wb_src", 32'(bus.wb_src), 32'd2);
        checkOutput("t1_rr_ptr", 32'(dut.r_rrPtr), 32'd3);
        tick();
        checkOutput("t1_drain", 32'(bus.wb_valid), 32'd0);

        // Source 3 alone walks the pointer back to 0.
        bus.src_data2 = dataOf(2);
        bus.src_rd2 = 5'd12;
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("t2_pre_ready", 32'(bus.src_ready), 32'b1000);
        tick();
        checkOutput("t2_pre_ptr", 32'(dut.r_rrPtr), 32'd0);

        applyStimulus(4'b1111, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t2_src_ready", 32'(bus.src_ready), 32'(4'b0001 << order[c]));
            tick();
            checkOutput("t2_wb_src", 32'(bus.wb_src), 32'(order[c]));
            checkOutput("t2_wb_data", bus.wb_data, dataOf(order[c]));
            checkOutput("t2_wb_valid", 32'(bus.wb_valid), 32'd1);
            checkOutput("t2_cnt", 32'(bus.conflict_cnt), 32'(c + 1));
        end
        checkOutput("t2_rr_ptr", 32'(dut.r_rrPtr), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        checkOutput("t2_drain", 32'(bus.wb_valid), 32'd0);

        // Stall with a held entry, then drain and refill on one edge.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("t3_fill_ready", 32'(bus.src_ready), 32'b0001);
        tick();
        checkOutput("t3_fill_src", 32'(bus.wb_src), 32'd0);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("t3_stall_ready", 32'(bus.src_ready), 32'd0);
            tick();
            checkOutput("t3_stall_valid", 32'(bus.wb_valid), 32'd1);
            checkOutput("t3_stall_src", 32'(bus.wb_src), 32'd0);
            checkOutput("t3_stall_data", bus.wb_data, dataOf(0));
            checkOutput("t3_stall_rd", 32'(bus.wb_rd), 32'd10);
        end
        checkOutput("t3_stall_cnt", 32'(bus.conflict_cnt), 32'd8);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("t3_refill_ready", 32'(bus.src_ready), 32'b0010);
        tick();
        checkOutput("t3_refill_valid", 32'(bus.wb_valid), 32'd1);
        checkOutput("t3_refill_src", 32'(bus.wb_src), 32'd1);
        checkOutput("t3_refill_data", bus.wb_data, dataOf(1));
        checkOutput("t3_refill_cnt", 32'(bus.conflict_cnt), 32'd9);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("t3_last_ready", 32'(bus.src_ready), 32'b0001);
        tick();
        checkOutput("t3_last_src", 32'(bus.wb_src), 32'd0);
        checkOutput("t3_last_ptr", 32'(dut.r_rrPtr), 32'd1);

        // Flush with a held entry and source 3 waiting.
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("t4_flush_ready", 32'(bus.src_ready), 32'd0);
        tick();
        checkOutput("t4_flush_valid", 32'(bus.wb_valid), 32'd0);
        checkOutput("t4_flush_ptr", 32'(dut.r_rrPtr), 32'd1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("t4_post_ready", 32'(bus.src_ready), 32'b1000);
        tick();
        checkOutput("t4_post_valid", 32'(bus.wb_valid), 32'd1);
        checkOutput("t4_post_src", 32'(bus.wb_src), 32'd3);
        checkOutput("t4_post_rd", 32'(bus.wb_rd), 32'd13);
        checkOutput("t4_post_ptr", 32'(dut.r_rrPtr), 32'd0);
        checkOutput("t4_cnt", 32'(bus.conflict_cnt), 32'd9);

        // Saturation of the conflict counter.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        force dut.r_conflictCnt = 16'hFFFE;
        tick();
        release dut.r_conflictCnt;
        #1;
        checkOutput("t5_forced", 32'(bus.conflict_cnt), 32'h0000_FFFE);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t5_sat", 32'(bus.conflict_cnt), 32'h0000_FFFF);
        end
        checkOutput("t5_full", 32'(bus.wb_valid), 32'd1);

        // Reset mid-stream with flush also asserted.
        rst = 1'b1;
        applyStimulus(4'b0011, 1'b1, 1'b1);
        tick();
        checkOutput("t6_wb_valid", 32'(bus.wb_valid), 32'd0);
        checkOutput("t6_wb_data", bus.wb_data, 32'd0);
        checkOutput("t6_wb_rd", 32'(bus.wb_rd), 32'd0);
        checkOutput("t6_wb_flags", 32'(bus.wb_flags), 32'd0);
        checkOutput("t6_wb_src", 32'(bus.wb_src), 32'd0);
        checkOutput("t6_src_ready", 32'(bus.src_ready), 32'd0);
        checkOutput("t6_cnt", 32'(bus.conflict_cnt), 32'd0);
        checkOutput("t6_rr_ptr", 32'(dut.r_rrPtr), 32'd0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
